// File: rtl/reg_arb_pkg.sv
// Shared widths and typedefs for the register-file write arbiter.
package reg_arb_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slotState_t;

    typedef enum logic {
        REQ_0 = 1'b0,
        REQ_1 = 1'b1
    } reqId_t;

    function automatic reqId_t otherReq(input reqId_t id);
        return (id == REQ_0) ? REQ_1 : REQ_0;
    endfunction

endpackage

// File: rtl/reg_arb_slot.sv
// One-entry holding slot for a write requester, with an age bit used to
// order two held writes that target the same register.
module reg_arb_slot
    import reg_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] loadReg,
    input  logic [DATA_W-1:0] loadData,
    input  logic              grant,
    input  logic              ageIn,
    output slotState_t        state,
    output logic [ADDR_W-1:0] heldReg,
    output logic [DATA_W-1:0] heldData,
    output logic              isOlder
);

    slotState_t stateNext;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // A granted slot may be refilled in the same cycle it drains.
    always_comb begin
        stateNext = state;
        case (state)
            SLOT_EMPTY: if (load) stateNext = SLOT_FULL;
            SLOT_FULL:  if (grant) stateNext = load ? SLOT_FULL : SLOT_EMPTY;
            default:    stateNext = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            heldReg  <= '0;
            heldData <= '0;
            isOlder  <= 1'b0;
        end else begin
            if (load) begin
                heldReg  <= loadReg;
                heldData <= loadData;
            end
            isOlder <= ageIn;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Two-requester register-file write arbiter with one holding slot per
// requester. Define REG_ARB_ROUND_ROBIN_EN for alternating grants under
// contention; otherwise requester 0 has fixed priority.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      Req0Valid,
    input  logic [ADDR_W-1:0]         Req0Reg,
    input  logic [DATA_W-1:0]         Req0Data,
    output logic                      Req0Ready,
    input  logic                      Req1Valid,
    input  logic [ADDR_W-1:0]         Req1Reg,
    input  logic [DATA_W-1:0]         Req1Data,
    output logic                      Req1Ready,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         WriteRegister,
    output logic [DATA_W-1:0]         WriteData,
    output logic [(2**ADDR_W)-1:0]    PendingMask,
    output logic                      Idle
);

    slotState_t        state0, state1;
    logic [ADDR_W-1:0] reg0, reg1;
    logic [DATA_W-1:0] data0, data1;
    logic              older0, older1;
    logic              full0, full1;
    logic              write0, write1;
    logic              keep0, keep1;
    logic              grant0, grant1, anyGrant;
    logic              slot0OlderNext;
    logic              readyEn;
    reqId_t            winner;

    // Ready stays low during reset and rises on the first edge after release.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            readyEn <= 1'b0;
        end else begin
            readyEn <= 1'b1;
        end
    end

    assign full0 = (state0 == SLOT_FULL);
    assign full1 = (state1 == SLOT_FULL);

    // Ready depends only on slot state and arbitration, never on Valid.
    assign Req0Ready = readyEn && (!full0 || grant0);
    assign Req1Ready = readyEn && (!full1 || grant1);

    // Writes to register 0 are accepted but never stored.
    assign write0 = Req0Valid && Req0Ready && (Req0Reg != '0);
    assign write1 = Req1Valid && Req1Ready && (Req1Reg != '0);

`ifdef REG_ARB_ROUND_ROBIN_EN
    reqId_t rrPtr;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rrPtr <= REQ_0;
        end else if (anyGrant) begin
            rrPtr <= otherReq(winner);
        end
    end
`endif

    // Same-register entries drain oldest first; otherwise the configured policy.
    always_comb begin
        winner = REQ_0;
        if (full0 && full1) begin
            if (reg0 == reg1) begin
                winner = (older1 && !older0) ? REQ_1 : REQ_0;
            end else begin
`ifdef REG_ARB_ROUND_ROBIN_EN
                winner = rrPtr;
`else
                winner = REQ_0;
`endif
            end
        end else if (full1) begin
            winner = REQ_1;
        end
    end

    assign anyGrant = full0 || full1;
    assign grant0   = anyGrant && (winner == REQ_0);
    assign grant1   = anyGrant && (winner == REQ_1);
    assign keep0    = full0 && !grant0;
    assign keep1    = full1 && !grant1;

    // A newly loaded entry is younger than any entry that remains held.
    always_comb begin
        slot0OlderNext = older0;
        if (write0 && write1) begin
            slot0OlderNext = 1'b1;
        end else if (write0) begin
            slot0OlderNext = !keep1;
        end else if (write1) begin
            slot0OlderNext = keep0;
        end
    end

    reg_arb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) uSlot0 (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .load     (write0),
        .loadReg  (Req0Reg),
        .loadData (Req0Data),
        .grant    (grant0),
        .ageIn    (slot0OlderNext),
        .state    (state0),
        .heldReg  (reg0),
        .heldData (data0),
        .isOlder  (older0)
    );

    reg_arb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) uSlot1 (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .load     (write1),
        .loadReg  (Req1Reg),
        .loadData (Req1Data),
        .grant    (grant1),
        .ageIn    (!slot0OlderNext),
        .state    (state1),
        .heldReg  (reg1),
        .heldData (data1),
        .isOlder  (older1)
    );

    // Output stage: the winner is presented for exactly one cycle; the
    // index and data hold their last values while RegWrite is low.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= anyGrant;
            if (anyGrant) begin
                WriteRegister <= (winner == REQ_1) ? reg1 : reg0;
                WriteData     <= (winner == REQ_1) ? data1 : data0;
            end
        end
    end

    // Decoded from the slot and output-stage flops, so a bit shared by two
    // entries stays set until the last of them leaves the output stage.
    always_comb begin
        PendingMask = '0;
        if (full0)    PendingMask[reg0] = 1'b1;
        if (full1)    PendingMask[reg1] = 1'b1;
        if (RegWrite) PendingMask[WriteRegister] = 1'b1;
    end

    assign Idle = !full0 && !full1 && !RegWrite;

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, write-data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register-index width (32 registers).
REQ-003 SHALL have one clock and an asynchronous active-low reset.
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- Req0Valid  in  1  requester 0 (pipeline writeback) has a write
- Req0Reg  in  ADDR_W  requester 0 destination index
- Req0Data  in  DATA_W  requester 0 data
- Req0Ready  out  1  requester 0 may transfer
- Req1Valid  in  1  requester 1 (multi-cycle unit) has a write
- Req1Reg  in  ADDR_W  requester 1 destination index
- Req1Data  in  DATA_W  requester 1 data
- Req1Ready  out  1  requester 1 may transfer
- RegWrite  out  1  write enable to the register file
- WriteRegister  out  ADDR_W  register-file write index
- WriteData  out  DATA_W  register-file write data
- PendingMask  out  2^ADDR_W  bit r set while a write to register r is held or presented
- Idle  out  1  no held or presented write

Function
REQ-004 SHALL accept a transfer on ReqNValid && ReqNReady at a rising edge.
REQ-005 SHALL keep one holding slot per requester, with states EMPTY and FULL; accept moves EMPTY->FULL, grant moves FULL->EMPTY, and accept plus grant in the same cycle leaves the slot FULL with the new entry.
REQ-006 SHALL drive ReqNReady = slot N EMPTY or slot N granted this cycle, with no combinational path from any Valid input to any Ready output.
REQ-007 SHALL discard accepted writes to register 0: the slot stays EMPTY, there is no grant, and no RegWrite pulse is issued.
REQ-008 SHALL grant at most one FULL slot per cycle and register the winner into the output stage, so RegWrite is high exactly one cycle per write.
REQ-009 SHALL present a write on the output stage one edge after acceptance (no contention); the register file commits it on the following edge.
REQ-010 SHALL sustain one write per cycle under continuous requests.
REQ-011 SHALL order writes by age when both slots hold the same WriteRegister: the older entry is granted first; on simultaneous acceptance, requester 0 is first.
REQ-012 SHALL set the PendingMask bit on acceptance and clear it on the edge after the presented write; a bit shared by two entries stays set until both complete.
REQ-013 SHALL drive Idle = both slots EMPTY and RegWrite low.
REQ-014 SHALL hold WriteRegister and WriteData at their last values while RegWrite is low.

Reset
REQ-015 SHALL, while Reset_n is low, force: both slots EMPTY, RegWrite=0, WriteRegister=0, WriteData=0, PendingMask=0, Idle=1, Req0Ready=Req1Ready=0, round-robin pointer=requester 0.
REQ-016 SHALL drop held and presented writes when reset asserts mid-operation; no RegWrite pulse follows reset release until a new acceptance.
REQ-017 SHALL raise Ready on the first edge after Reset_n deasserts.

Configuration
REQ-018 SHALL implement the macro REG_ARB_ROUND_ROBIN_EN: when defined, age-independent contention alternates grants, starting from the requester not granted last; when undefined, requester 0 always wins and requester 1 waits. REQ-011 ordering holds in both modes.

Structure
REQ-019 SHALL place DATA_W/ADDR_W defaults, the slot-state typedef (EMPTY/FULL) and the requester-id typedef in shared package reg_arb_pkg.
REQ-020 SHALL instantiate one sub-module, reg_arb_slot (holding slot with age bit), twice.

Verification
REQ-021 Single write: Req0 writes R8=0x88888888 at cycle 0 -> RegWrite high cycle 1, WriteRegister=8; a RegisterFile read of R8 next cycle returns 0x88888888.
REQ-022 Contention (ROUND_ROBIN_EN): both write R9/R10 continuously for 4 cycles -> grants alternate 0,1,0,1; no write lost; Ready never low for two consecutive cycles.
REQ-023 Same-register ordering: Req1 writes R12=0x1 at cycle 0, Req0 writes R12=0x2 at cycle 1 -> R12 written 0x1 then 0x2; final value 0x2.
REQ-024 Register 0: Req0 writes R0=0xFFFFFFFF -> no RegWrite pulse; PendingMask stays 0; Idle stays 1.
REQ-025 Reset mid-operation: Reset_n low while both slots are FULL -> RegWrite=0, PendingMask=0 immediately; no write after release.
REQ-026 Fixed priority (macro undefined): Req0 valid 3 cycles, Req1 valid throughout -> Req1 granted only after Req0 drops.
